// File: rtl/ila_check_sequencer.sv
// -----------------------------------------------------------------------------
// ila_check_sequencer
//
// Sequences one instruction-level refinement check of the 4-register undetfunc
// datapath. It sits in the generated check wrapper between the ILA model
// instance and the RTL instance. It produces the start/end timing that gates
// the variable-map assumptions (at start) and the assertions (at end). It also
// drives the capture strobe for the undetermined-function result registers.
//
// Optional feature macro: ILA_CHK_TIMEOUT_EN
//   Defined   : timeout is a sticky flag. It is set when the counter saturates
//               while the check is running and has not yet ended.
//   Undefined : timeout is tied to 0 and no timeout logic is built.
//
// Parameters
//   CNT_W      width of the cycle counter
//   END_CYCLE  counter value at which the instruction is declared finished
//   MAX_CYCLE  counter saturation value (< 2**CNT_W)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   issue        in   issue condition, only looked at while idle
//   ila_valid    in   ILA valid
//   ila_decode   in   ILA decode of the checked instruction
//   early_end    in   extra end condition, ORed into the end condition
//   dummy_reset  in   reset seen by the RTL instance
//   start        out  one-cycle pulse: assumptions apply, model steps
//   started      out  sticky: check in progress or done
//   cycle_cnt    out  cycles since start, saturating at MAX_CYCLE
//   iend         out  one-cycle instruction-end pulse: assertions apply
//   ended        out  sticky: iend has occurred
//   second_end   out  pulse on the first end condition after ended
//   reseted      out  sticky: rst has been applied at least once
//   noreset_ok   out  assumption: ~reseted | ~dummy_reset
//   issue_ok     out  assumption: ~start | (ila_valid & ila_decode)
//   capture_en   out  result registers load while rst is high
//   timeout      out  see macro description above
// -----------------------------------------------------------------------------
module ila_check_sequencer #(
    parameter int CNT_W     = 4,
    parameter int END_CYCLE = 1,
    parameter int MAX_CYCLE = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic             ila_valid,
    input  logic             ila_decode,
    input  logic             early_end,
    input  logic             dummy_reset,
    output logic             start,
    output logic             started,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             iend,
    output logic             ended,
    output logic             second_end,
    output logic             reseted,
    output logic             noreset_ok,
    output logic             issue_ok,
    output logic             capture_en,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] END_VAL = CNT_W'(END_CYCLE);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_CYCLE);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ended_q;
    logic             second_ended_q;
    logic             reseted_q;
    logic             edcond;

    // State register. reseted_q is only ever written on reset, so it holds
    // its 0 power-up value until the first rst and then stays 1 forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ended_q        <= 1'b0;
            second_ended_q <= 1'b0;
            reseted_q      <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (iend) begin
                ended_q <= 1'b1;
            end
            if (second_end) begin
                second_ended_q <= 1'b1;
            end
        end
    end

    // Next-state logic. DONE is terminal until rst: a completed check can
    // never be re-issued, so issue is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (issue) state_d = ST_START;
            ST_START: state_d = ST_RUN;
            ST_RUN:   if (ended_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign start   = (state_q == ST_START);
    assign started = (state_q == ST_RUN) || (state_q == ST_DONE);

    // Saturating counter. It starts counting on the start cycle, so it reads
    // 1 in the first started cycle.
    always_comb begin
        cnt_d = cnt_q;
        if ((start || started) && (cnt_q < MAX_VAL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cnt_q;

    assign edcond     = ((cnt_q == END_VAL) || early_end) && started;
    assign iend       = edcond && reseted_q && !ended_q;
    assign second_end = ended_q && edcond && !second_ended_q;
    assign ended      = ended_q;
    assign reseted    = reseted_q;

    assign noreset_ok = !reseted_q || !dummy_reset;
    assign issue_ok   = !start || (ila_valid && ila_decode);
    assign capture_en = rst;

`ifdef ILA_CHK_TIMEOUT_EN
    logic timeout_q;

    // A check that saturates the counter without ending never produces an
    // assertion point, so flag it for the wrapper.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if ((cnt_q == MAX_VAL) && started && !ended_q) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ila_check_sequencer.sv
module tb_ila_check_sequencer;

    localparam int CNT_W = 4;
    localparam int END_C = 1;
    localparam int MAX_C = 6;

`ifdef ILA_CHK_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic issue = 1'b0;
    logic ila_valid = 1'b0;
    logic ila_decode = 1'b0;
    logic early_end = 1'b0;
    logic dummy_reset = 1'b0;

    logic             start, started, iend, ended, second_end, reseted;
    logic             noreset_ok, issue_ok, capture_en, timeout;
    logic [CNT_W-1:0] cycle_cnt;

    // Second instance with an unreachable end cycle, used for the timeout.
    logic             to_start, to_started, to_iend, to_ended, to_second_end, to_reseted;
    logic             to_noreset_ok, to_issue_ok, to_capture_en, to_timeout;
    logic [CNT_W-1:0] to_cycle_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ila_check_sequencer #(.CNT_W(CNT_W), .END_CYCLE(END_C), .MAX_CYCLE(MAX_C)) dut (
        .clk(clk), .rst(rst), .issue(issue), .ila_valid(ila_valid),
        .ila_decode(ila_decode), .early_end(early_end), .dummy_reset(dummy_reset),
        .start(start), .started(started), .cycle_cnt(cycle_cnt), .iend(iend),
        .ended(ended), .second_end(second_end), .reseted(reseted),
        .noreset_ok(noreset_ok), .issue_ok(issue_ok), .capture_en(capture_en),
        .timeout(timeout)
    );

    ila_check_sequencer #(.CNT_W(CNT_W), .END_CYCLE(7), .MAX_CYCLE(MAX_C)) dut_to (
        .clk(clk), .rst(rst), .issue(issue), .ila_valid(ila_valid),
        .ila_decode(ila_decode), .early_end(early_end), .dummy_reset(dummy_reset),
        .start(to_start), .started(to_started), .cycle_cnt(to_cycle_cnt), .iend(to_iend),
        .ended(to_ended), .second_end(to_second_end), .reseted(to_reseted),
        .noreset_ok(to_noreset_ok), .issue_ok(to_issue_ok), .capture_en(to_capture_en),
        .timeout(to_timeout)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle; returns at cycle 0 with all inputs low.
    task automatic do_reset();
        rst = 1'b1;
        issue = 1'b0;
        early_end = 1'b0;
        dummy_reset = 1'b0;
        ila_valid = 1'b0;
        ila_decode = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (capture_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_capture_en: got %b expected 1", capture_en);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({start, started, iend, ended, second_end, reseted, capture_en} !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000010",
                     {start, started, iend, ended, second_end, reseted, capture_en});
        end
        checks++;
        if (cycle_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt);
        end
        checks++;
        if (timeout !== 1'b0 || to_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_timeout: got %b%b expected 00", timeout, to_timeout);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_run();
        do_reset();
        issue = 1'b1;
        #1;
        checks++;
        if (start !== 1'b0) begin
            errors++;
            $display("FAIL basic_c0_start: got %b expected 0", start);
        end
        tick();
        issue = 1'b0;
        #1;
        checks++;
        if ({start, started, iend, ended} !== 4'b1000 || cycle_cnt !== 4'd0) begin
            errors++;
            $display("FAIL basic_c1: got flags %b cnt %0d expected 1000 cnt 0",
                     {start, started, iend, ended}, cycle_cnt);
        end
        tick();
        checks++;
        if ({start, started, iend, ended} !== 4'b0110 || cycle_cnt !== 4'd1) begin
            errors++;
            $display("FAIL basic_c2: got flags %b cnt %0d expected 0110 cnt 1",
                     {start, started, iend, ended}, cycle_cnt);
        end
        tick();
        checks++;
        if ({start, started, iend, ended} !== 4'b0101 || cycle_cnt !== 4'd2) begin
            errors++;
            $display("FAIL basic_c3: got flags %b cnt %0d expected 0101 cnt 2",
                     {start, started, iend, ended}, cycle_cnt);
        end
        repeat (4) tick();
        checks++;
        if (cycle_cnt !== 4'd6) begin
            errors++;
            $display("FAIL basic_c7_cnt: got %0d expected 6", cycle_cnt);
        end
        tick();
        checks++;
        if (cycle_cnt !== 4'd6 || {started, ended, iend} !== 3'b110) begin
            errors++;
            $display("FAIL basic_c8_sat: got cnt %0d flags %b expected cnt 6 flags 110",
                     cycle_cnt, {started, ended, iend});
        end
        $display("test_basic_run done");
    endtask

    task automatic test_issue_blocking();
        int n_start;
        int n_iend;
        n_start = 0;
        n_iend = 0;
        do_reset();
        issue = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) issue = 1'b0;
            #1;
            n_start += int'(start);
            n_iend += int'(iend);
            tick();
        end
        checks++;
        if (n_start != 1) begin
            errors++;
            $display("FAIL block_start_count: got %0d expected 1", n_start);
        end
        checks++;
        if (n_iend != 1) begin
            errors++;
            $display("FAIL block_iend_count: got %0d expected 1", n_iend);
        end
        $display("test_issue_blocking done: starts=%0d iends=%0d", n_start, n_iend);
    endtask

    task automatic test_second_end();
        do_reset();
        issue = 1'b1;
        tick();
        issue = 1'b0;
        repeat (3) tick();
        early_end = 1'b1;
        #1;
        checks++;
        if ({second_end, iend} !== 2'b10) begin
            errors++;
            $display("FAIL second_end_c4: got %b expected 10", {second_end, iend});
        end
        tick();
        early_end = 1'b0;
        #1;
        checks++;
        if (second_end !== 1'b0) begin
            errors++;
            $display("FAIL second_end_c5: got %b expected 0", second_end);
        end
        tick();
        early_end = 1'b1;
        #1;
        checks++;
        if (second_end !== 1'b0) begin
            errors++;
            $display("FAIL second_end_c6: got %b expected 0", second_end);
        end
        early_end = 1'b0;
        $display("test_second_end done");
    endtask

    task automatic test_mid_reset();
        do_reset();
        issue = 1'b1;
        tick();
        issue = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({iend, capture_en} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_c2: got iend,capture_en %b expected 11", {iend, capture_en});
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({start, started, ended, iend, reseted} !== 5'b00001 || cycle_cnt !== 4'd0) begin
            errors++;
            $display("FAIL midrst_c3: got flags %b cnt %0d expected 00001 cnt 0",
                     {start, started, ended, iend, reseted}, cycle_cnt);
        end
        issue = 1'b1;
        tick();
        issue = 1'b0;
        #1;
        checks++;
        if (start !== 1'b1) begin
            errors++;
            $display("FAIL midrst_reissue: got %b expected 1", start);
        end
        $display("test_mid_reset done");
    endtask

    task automatic test_assumptions();
        do_reset();
        dummy_reset = 1'b1;
        #1;
        checks++;
        if (noreset_ok !== 1'b0) begin
            errors++;
            $display("FAIL noreset_ok_dummy1: got %b expected 0", noreset_ok);
        end
        dummy_reset = 1'b0;
        #1;
        checks++;
        if (noreset_ok !== 1'b1) begin
            errors++;
            $display("FAIL noreset_ok_dummy0: got %b expected 1", noreset_ok);
        end
        issue = 1'b1;
        tick();
        issue = 1'b0;
        ila_valid = 1'b1;
        ila_decode = 1'b0;
        #1;
        checks++;
        if (issue_ok !== 1'b0) begin
            errors++;
            $display("FAIL issue_ok_nodecode: got %b expected 0", issue_ok);
        end
        ila_decode = 1'b1;
        #1;
        checks++;
        if (issue_ok !== 1'b1) begin
            errors++;
            $display("FAIL issue_ok_decode: got %b expected 1", issue_ok);
        end
        tick();
        ila_valid = 1'b0;
        ila_decode = 1'b0;
        #1;
        checks++;
        if (issue_ok !== 1'b1) begin
            errors++;
            $display("FAIL issue_ok_nostart: got %b expected 1", issue_ok);
        end
        $display("test_assumptions done");
    endtask

    task automatic test_timeout();
        do_reset();
        issue = 1'b1;
        tick();
        issue = 1'b0;
        repeat (6) tick();
        checks++;
        if (to_timeout !== 1'b0 || to_cycle_cnt !== 4'd6) begin
            errors++;
            $display("FAIL timeout_c7: got timeout %b cnt %0d expected 0 cnt 6",
                     to_timeout, to_cycle_cnt);
        end
        tick();
        checks++;
        if (to_timeout !== TO_EXP) begin
            errors++;
            $display("FAIL timeout_c8: got %b expected %b", to_timeout, TO_EXP);
        end
        repeat (2) tick();
        checks++;
        if (to_timeout !== TO_EXP || to_ended !== 1'b0) begin
            errors++;
            $display("FAIL timeout_c10: got timeout %b ended %b expected %b 0",
                     to_timeout, to_ended, TO_EXP);
        end
        do_reset();
        #1;
        checks++;
        if (to_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_cleared: got %b expected 0", to_timeout);
        end
        $display("test_timeout done");
    endtask

    // Reference model: the check is described by the cycle index at which
    // start pulses (m_sc, -1 when idle) plus the ended/second-ended/timeout
    // flags. All outputs follow from elapsed time since start.
    task automatic test_random();
        int   now;
        int   m_sc;
        bit   m_end, m_sec, m_to;
        bit   e_start, e_started, e_ed, e_iend, e_sec;
        int   e_cnt;
        logic [13:0] exp_v, got_v;
        do_reset();
        now = 0;
        m_sc = -1;
        m_end = 0;
        m_sec = 0;
        m_to = 0;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(39) == 0);
            issue = ($urandom_range(5) == 0);
            early_end = ($urandom_range(4) == 0);
            dummy_reset = 1'($urandom_range(1));
            ila_valid = 1'($urandom_range(1));
            ila_decode = 1'($urandom_range(1));
            #1;
            e_start = (m_sc == now);
            e_started = (m_sc >= 0) && (now > m_sc);
            e_cnt = e_started ? ((now - m_sc) > MAX_C ? MAX_C : (now - m_sc)) : 0;
            e_ed = e_started && ((e_cnt == END_C) || early_end);
            e_iend = e_ed && !m_end;
            e_sec = m_end && e_ed && !m_sec;
            exp_v = {e_start, e_started, 4'(e_cnt), e_iend, m_end, e_sec, 1'b1,
                     !dummy_reset, !e_start || (ila_valid && ila_decode), rst, m_to};
            got_v = {start, started, cycle_cnt, iend, ended, second_end, reseted,
                     noreset_ok, issue_ok, capture_en, timeout};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %b expected %b", i, got_v, exp_v);
            end else begin
                $display("random %0d: rst=%b issue=%b early=%b outputs=%b",
                         i, rst, issue, early_end, got_v);
            end
            if (rst) begin
                m_sc = -1;
                m_end = 0;
                m_sec = 0;
                m_to = 0;
            end else begin
`ifdef ILA_CHK_TIMEOUT_EN
                if (e_cnt == MAX_C && e_started && !m_end) m_to = 1;
`endif
                if (m_sc < 0 && issue) m_sc = now + 1;
                if (e_iend) m_end = 1;
                if (e_sec) m_sec = 1;
            end
            now++;
            tick();
        end
        rst = 1'b0;
        issue = 1'b0;
        early_end = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_issue_blocking();
        test_second_end();
        test_mid_reset();
        test_assumptions();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
